// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - op codes, shift-register commands, amount selects and state encoding
package shift_seq_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b011;
  localparam logic [2:0] OP_SRLV = 3'b100;
  localparam logic [2:0] OP_SRAV = 3'b101;
  localparam logic [2:0] OP_LUI  = 3'b110;
  localparam logic [2:0] OP_SRAM = 3'b111;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] LEFT = 3'b010;
  localparam logic [2:0] RLOG = 3'b011;
  localparam logic [2:0] RARI = 3'b100;

  localparam logic [1:0] SEL_SHAMT = 2'b00;
  localparam logic [1:0] SEL_RS    = 2'b01;
  localparam logic [1:0] SEL_MEM   = 2'b10;
  localparam logic [1:0] SEL_C16   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_op_decode.sv
// rtl/shift_op_decode.sv - op to amount select, data source and direction command
module shift_op_decode
  import shift_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic [1:0] shift_sel,
  output logic       shift_src,
  output logic [2:0] dir
);

  always_comb begin
    shift_sel = SEL_SHAMT;
    shift_src = 1'b0;
    dir       = NOP;
    case (op)
      OP_SLL:  begin shift_sel = SEL_SHAMT; shift_src = 1'b0; dir = LEFT; end
      OP_SRL:  begin shift_sel = SEL_SHAMT; shift_src = 1'b0; dir = RLOG; end
      OP_SRA:  begin shift_sel = SEL_SHAMT; shift_src = 1'b0; dir = RARI; end
      OP_SLLV: begin shift_sel = SEL_RS;    shift_src = 1'b0; dir = LEFT; end
      OP_SRLV: begin shift_sel = SEL_RS;    shift_src = 1'b0; dir = RLOG; end
      OP_SRAV: begin shift_sel = SEL_RS;    shift_src = 1'b0; dir = RARI; end
      OP_LUI:  begin shift_sel = SEL_C16;   shift_src = 1'b1; dir = LEFT; end
      OP_SRAM: begin shift_sel = SEL_MEM;   shift_src = 1'b1; dir = RARI; end
      default: begin shift_sel = SEL_SHAMT; shift_src = 1'b0; dir = NOP;  end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load/shift/done sequencer for the shift-register datapath
// Optional zero-amount skip of the SHIFT state: SHIFT_ZERO_SKIP_EN
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int SHAMT_W   = 5,
  parameter int CONST_AMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [SHAMT_W-1:0] rs_amt,
  input  logic [SHAMT_W-1:0] mem_amt,
  output logic               busy,
  output logic               done,
  output logic [1:0]         shift_sel,
  output logic               shift_src,
  output logic [2:0]         shift_ctrl
);

  localparam logic [SHAMT_W-1:0] CONST_V = CONST_AMT[SHAMT_W-1:0];

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [2:0]         dec_op;
  logic [1:0]         dec_sel;
  logic               dec_src;
  logic [2:0]         dec_dir;
  logic [SHAMT_W-1:0] sel_amt;
  logic               amt_zero_q;
  logic               accept;

  logic               busy_d, done_d, src_d;
  logic [1:0]         sel_d;
  logic [2:0]         ctrl_d;

  // Decode live op on the accepting edge, the frozen copy afterwards
  assign accept = (state_q == ST_IDLE) && start;
  assign dec_op = (state_q == ST_IDLE) ? op : op_q;

  shift_op_decode u_dec (
    .op        (dec_op),
    .shift_sel (dec_sel),
    .shift_src (dec_src),
    .dir       (dec_dir)
  );

  always_comb begin
    sel_amt = shamt;
    case (dec_sel)
      SEL_SHAMT: sel_amt = shamt;
      SEL_RS:    sel_amt = rs_amt;
      SEL_MEM:   sel_amt = mem_amt;
      SEL_C16:   sel_amt = CONST_V;
      default:   sel_amt = shamt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_SLL;
      amt_zero_q <= 1'b0;
    end else if (accept) begin
      op_q       <= op;
      amt_zero_q <= (sel_amt == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
`ifdef SHIFT_ZERO_SKIP_EN
      ST_LOAD:  state_d = amt_zero_q ? ST_DONE : ST_SHIFT;
`else
      ST_LOAD:  state_d = ST_SHIFT;
`endif
      ST_SHIFT: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifndef SHIFT_ZERO_SKIP_EN
  logic unused_amt_zero;
  assign unused_amt_zero = amt_zero_q;
`endif

  // Outputs are computed for the state being entered and registered with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    sel_d  = SEL_SHAMT;
    src_d  = 1'b0;
    ctrl_d = NOP;
    case (state_d)
      ST_LOAD: begin
        busy_d = 1'b1;
        sel_d  = dec_sel;
        src_d  = dec_src;
        ctrl_d = LOAD;
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        sel_d  = dec_sel;
        src_d  = dec_src;
        ctrl_d = dec_dir;
      end
      ST_DONE: begin
        done_d = 1'b1;
        sel_d  = dec_sel;
        src_d  = dec_src;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_sel  <= SEL_SHAMT;
      shift_src  <= 1'b0;
      shift_ctrl <= NOP;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      shift_sel  <= sel_d;
      shift_src  <= src_d;
      shift_ctrl <= ctrl_d;
    end
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle controller for the shift-register datapath.
- Accepts one shift instruction at a time, then drives three things in order: the shift-amount mux select, the shift-data source select and the shift-register command.
- Sequence per instruction: load, shift, completion pulse to the main control FSM.
- Sits between the main control unit and the shift amount mux / shift register.

Parameters:
- SHAMT_W, 5, width of every shift-amount input.
- CONST_AMT, 16, fixed amount the mux supplies on select 2'b11; used only for zero detection.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  operation code; latched with start.
- shamt  input  SHAMT_W  instruction shamt field.
- rs_amt  input  SHAMT_W  low bits of register A.
- mem_amt  input  SHAMT_W  low bits of memory data.
- busy  output  1  high from the cycle after acceptance through the last SHIFT cycle.
- done  output  1  one-cycle completion pulse; shift result is valid this cycle.
- shift_sel  output  2  amount mux select: 00 shamt, 01 rs_amt, 10 mem_amt, 11 constant 16.
- shift_src  output  1  data source: 0 register B, 1 alternate (immediate/memory).
- shift_ctrl  output  3  shift-register command: 000 nop, 001 load, 010 left, 011 right logical, 100 right arithmetic.

Behaviour:
- Op decode (op -> shift_sel, shift_src, direction):
  - 000 SLL -> 00, 0, left
  - 001 SRL -> 00, 0, right logical
  - 010 SRA -> 00, 0, right arithmetic
  - 011 SLLV -> 01, 0, left
  - 100 SRLV -> 01, 0, right logical
  - 101 SRAV -> 01, 0, right arithmetic
  - 110 LUI -> 11, 1, left
  - 111 SRAM -> 10, 1, right arithmetic
- States: IDLE, LOAD, SHIFT, DONE.
- Transitions:
  - IDLE: start=1 -> LOAD; latch op, and latch the selected amount at the same edge.
  - LOAD -> SHIFT.
  - SHIFT -> DONE.
  - DONE -> IDLE.
- Outputs per state:
  - IDLE: all outputs 0.
  - LOAD: shift_ctrl=001; shift_src decoded; shift_sel decoded; busy=1.
  - SHIFT: shift_ctrl=direction code; shift_sel and shift_src held; busy=1.
  - DONE: shift_ctrl=000; done=1; busy=0; shift_sel and shift_src still held.
- Latency: start edge to done = 3 cycles (LOAD, SHIFT, DONE).
- Latched values: op and amount are frozen while busy; later changes on op, shamt, rs_amt or mem_amt have no effect.
- start outside IDLE (including DONE) is ignored and never queued. The earliest next acceptance is the first IDLE cycle, so back-to-back requests occur at most every 4 cycles.
- All outputs are registered (Moore).
- Reset asserted at any time: immediately go to IDLE; busy, done, shift_sel, shift_src and shift_ctrl all 0; the in-flight operation is dropped with no done.
- On reset release, the first rising edge may accept start.
- Every 3-bit op is legal; there is no error path.

Optional Feature:
- Macro: SHIFT_ZERO_SKIP_EN.
- Defined: if the latched amount is 0, LOAD goes directly to DONE. shift_ctrl stays 001 for LOAD and is never a shift command; latency is 2 cycles. LUI never skips, because its amount is CONST_AMT.
- Undefined: no zero detection; SHIFT is always visited, so a zero-amount op drives the direction command with amount 0. Latency is always 3.

Decomposition:
- Package shift_seq_pkg holds:
  - op code localparams;
  - shift_ctrl codes (NOP, LOAD, LEFT, RLOG, RARI);
  - shift_sel codes (SEL_SHAMT, SEL_RS, SEL_MEM, SEL_C16);
  - state encoding (2 bits).
- One combinational sub-module, shift_op_decode: op -> {shift_sel, shift_src, direction code}, shared with the main control unit.

Test Plan:
- Reset mid-op: start SRA shamt=3, assert reset during SHIFT -> all outputs 0 immediately; done never pulses; a new start one edge after release is accepted.
- Basic SLL: op=000, shamt=4, start for 1 cycle -> LOAD (ctrl 001, sel 00, src 0), SHIFT (ctrl 010), done=1 exactly 3 cycles after the start edge; busy high for 2 cycles.
- SRAV latch: op=101, rs_amt=7, then change rs_amt to 0 during LOAD -> sel 01, ctrl 100 in SHIFT, no skip even with SHIFT_ZERO_SKIP_EN.
- LUI/SRAM: op=110 -> sel 11, src 1, ctrl 010. Op=111 with mem_amt=2 -> sel 10, src 1, ctrl 100.
- Zero amount: SLL shamt=0 -> with SHIFT_ZERO_SKIP_EN, done 2 cycles after start and no ctrl 010 cycle; without it, done at 3 cycles.
- Busy/DONE start: start held high continuously -> accepted exactly every 4 cycles; pulses during LOAD, SHIFT or DONE produce no extra done.
